irq_stack_sequencer: RTL and testbench
======================================

Name: irq_stack_sequencer

Overview:
- Parametrised interrupt/reset entry sequencer for the tinymos6502 core; takes over the address/data bus between instructions.
- Performs reset-vector fetch, NMI/IRQ/BRK entry: push PCH, PCL, P to stack page, fetch vector, load PC.
- Generalises the single IRQ/NMI pins to NUM_IRQ maskable, prioritised, optionally vectored IRQ channels.
- Sits beside the decoder; decoder asserts INSN_BOUNDARY, and the sequencer owns the bus while BUSY=1.

Parameters:
- DATA_WIDTH, 8, data bus width (P register and SP are fixed at 8 bits)
- ADDR_WIDTH, 16, address bus width
- NUM_IRQ, 4, number of IRQ request channels (1..8)
- STACK_PAGE, 8'h01, high address byte for stack pushes
- VEC_BASE, 16'hFFE0, vector base for IRQ channels k>=1

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- RDY  in  1  high = advance; low = freeze state and all outputs
- NMI  in  1  non-maskable request, rising-edge sensitive
- IRQ  in  NUM_IRQ  level requests, active high
- IRQ_MASK  in  NUM_IRQ  per-channel enable (1 = enabled)
- I_FLAG  in  1  processor interrupt-disable flag
- BRK_REQ  in  1  decoder executing BRK
- INSN_BOUNDARY  in  1  last cycle of current instruction
- PC_IN  in  ADDR_WIDTH  return address to push
- PSR_IN  in  8  processor status to push
- SP_IN  in  8  current stack pointer
- DATA_IN  in  DATA_WIDTH  read data from bus
- ADDRESS  out  ADDR_WIDTH  bus address while BUSY
- DATA_OUT  out  DATA_WIDTH  write data
- RW  out  1  1 = read, 0 = write
- BUSY  out  1  sequencer owns bus
- PC_OUT  out  ADDR_WIDTH  vector loaded into PC
- PC_WE  out  1  one-cycle PC load strobe
- SP_OUT  out  8  updated stack pointer
- SP_WE  out  1  one-cycle SP load strobe
- SET_I  out  1  one-cycle strobe: set I flag
- IRQ_ID  out  $clog2(NUM_IRQ)+1  serviced source: 0 = NMI/RESET/BRK, k+1 = IRQ channel k

Behaviour:
- States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD_PC. Each state lasts one cycle with RDY=1; with RDY=0, state, registers and outputs hold.
- Reset values: state=VEC_LO, vector=16'hFFFC, kind=RESET, BUSY=1, RW=1, PC_WE=SP_WE=SET_I=0, NMI pending=0, IRQ_ID=0.
  - Reset sequence skips pushes: VEC_LO, VEC_HI, LOAD_PC, IDLE.
  - Reset asserted mid-sequence aborts it immediately; no partial SP_WE.
- NMI: rising edge (registered previous value) sets nmi_pend; the flag holds until the sequence enters PUSH_PCH for NMI.
- Source selection, sampled in IDLE on INSN_BOUNDARY=1 & RDY=1:
  - Priority: nmi_pend > BRK_REQ > lowest-index channel k with IRQ[k] & IRQ_MASK[k] & !I_FLAG.
  - No request: stay in IDLE.
- Push phase: writes use RW=0, ADDRESS={STACK_PAGE, sp}, with sp starting at SP_IN and decrementing mod 256 after each push.
  - PUSH_PCH writes PC_IN[15:8]; PUSH_PCL writes PC_IN[7:0].
  - PUSH_P writes PSR_IN with bit5=1; bit4=1 for BRK, bit4=0 for NMI/IRQ.
- Vectors: NMI FFFA; RESET FFFC; BRK and IRQ channel 0 FFFE; IRQ channel k>=1 VEC_BASE+2k.
  - VEC_LO reads vector, VEC_HI reads vector+1; both RW=1. Low byte is latched at VEC_LO.
- LOAD_PC: PC_OUT={hi,lo}, PC_WE=1, SET_I=1; SP_OUT=SP_IN-3 (mod 256) with SP_WE=1 unless RESET. Then IDLE, BUSY=0.
- Latency from INSN_BOUNDARY to PC_WE: 6 cycles.
- IRQ dropped after selection: the sequence still completes with the selected vector.
- IDLE outputs: BUSY=0, RW=1, ADDRESS=0, DATA_OUT=0.

Optional Feature:
- Macro: TINYMOS6502_NMI_HIJACK_EN.
- Defined: an NMI edge seen while in PUSH_PCH..PUSH_P of an IRQ/BRK sequence redirects the vector to FFFA and clears nmi_pend. Pushed P keeps its bit4 value; IRQ_ID becomes 0.
- Undefined: NMI stays pending and is serviced at the next INSN_BOUNDARY.

Decomposition:
- Package tinymos6502_pkg holds:
  - state enum
  - vector constants NMI_VEC, RST_VEC, IRQ_VEC
  - PSR bit index constants (B=4, U=5)
- Sub-module irq_priority_enc: masked, I-gated lowest-index priority encoder with valid output.

Test Plan:
- Release reset, RDY=1, DATA_IN=34 at FFFC, 12 at FFFD -> PC_OUT=16'h1234 with PC_WE on cycle 3; no writes; SP_WE=0.
- SP_IN=FF, PC_IN=C005, PSR_IN=03, IRQ[0]=1, I_FLAG=0, boundary -> writes C0@01FF, 05@01FE, 23@01FD; reads FFFE/FFFF; SP_OUT=FC.
- IRQ[2]=1 and IRQ[1]=1 with mask 4'b0100 -> channel 2 serviced, vector E4/E5, IRQ_ID=3. With I_FLAG=1 -> stays IDLE.
- NMI pulse and IRQ[0] at same boundary -> FFFA serviced first. IRQ still high -> IRQ entered at the next boundary.
- BRK_REQ with PSR_IN=00 -> pushed P=30, vector FFFE. Hold RDY=0 for 3 cycles in PUSH_PCL -> outputs frozen, total latency 9.
- With the macro defined, NMI edge during PUSH_PCL of an IRQ -> reads FFFA/FFFB. Without it -> FFFE read, then NMI entry next boundary.

Source files
------------

// File: rtl/tinymos6502_pkg.sv
// rtl/tinymos6502_pkg.sv - shared states, vectors and PSR bit positions for the tinymos6502 interrupt sequencer
package tinymos6502_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUSH_PCH,
      S_PUSH_PCL,
      S_PUSH_P,
      S_VEC_LO,
      S_VEC_HI,
      S_LOAD_PC
   } seq_state_e;

   typedef enum logic [1:0] {
      K_RESET,
      K_NMI,
      K_BRK,
      K_IRQ
   } entry_kind_e;

   localparam logic [15:0] NMI_VEC = 16'hFFFA;
   localparam logic [15:0] RST_VEC = 16'hFFFC;
   localparam logic [15:0] IRQ_VEC = 16'hFFFE;

   localparam int PSR_B = 4;
   localparam int PSR_U = 5;

   // Channel 0 shares the legacy IRQ/BRK vector; higher channels are vectored off a base.
   function automatic logic [15:0] irq_vector(input logic [15:0] base, input logic [7:0] k);
      if (k == 8'd0) begin
         return IRQ_VEC;
      end
      return base + {7'd0, k, 1'b0};
   endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// rtl/irq_priority_enc.sv - masked, I-flag gated, lowest-index-wins IRQ priority encoder
module irq_priority_enc
   import tinymos6502_pkg::*;
#(
   parameter int NUM_IRQ = 4,
   parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic [NUM_IRQ-1:0] mask_i,
   input  logic               i_flag_i,
   output logic               valid_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic [NUM_IRQ-1:0] req;

   assign req = irq_i & mask_i & {NUM_IRQ{~i_flag_i}};

   // Scan from the top down so the lowest active index is the last one written.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         if (req[k]) begin
            valid_o = 1'b1;
            idx_o   = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/irq_stack_sequencer.sv
// rtl/irq_stack_sequencer.sv - reset/NMI/BRK/IRQ entry sequencer; TINYMOS6502_NMI_HIJACK_EN enables late-NMI vector hijack
module irq_stack_sequencer
   import tinymos6502_pkg::*;
#(
   parameter int          DATA_WIDTH = 8,
   parameter int          ADDR_WIDTH = 16,
   parameter int          NUM_IRQ    = 4,
   parameter logic [7:0]  STACK_PAGE = 8'h01,
   parameter logic [15:0] VEC_BASE   = 16'hFFE0,
   localparam int         ID_W       = $clog2(NUM_IRQ) + 1,
   localparam int         IDX_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  rdy_i,
   input  logic                  nmi_i,
   input  logic [NUM_IRQ-1:0]    irq_i,
   input  logic [NUM_IRQ-1:0]    irq_mask_i,
   input  logic                  i_flag_i,
   input  logic                  brk_req_i,
   input  logic                  insn_boundary_i,
   input  logic [ADDR_WIDTH-1:0] pc_in_i,
   input  logic [7:0]            psr_in_i,
   input  logic [7:0]            sp_in_i,
   input  logic [DATA_WIDTH-1:0] data_in_i,
   output logic [ADDR_WIDTH-1:0] address_o,
   output logic [DATA_WIDTH-1:0] data_out_o,
   output logic                  rw_o,
   output logic                  busy_o,
   output logic [ADDR_WIDTH-1:0] pc_out_o,
   output logic                  pc_we_o,
   output logic [7:0]            sp_out_o,
   output logic                  sp_we_o,
   output logic                  set_i_o,
   output logic [ID_W-1:0]       irq_id_o
);

   seq_state_e  state_q, state_d;
   entry_kind_e kind_q, kind_d;
   logic [15:0] vec_q, vec_d;
   logic [7:0]  sp_q, sp_d;
   logic [7:0]  lo_q, lo_d;
   logic [7:0]  hi_q, hi_d;
   logic [ID_W-1:0] id_q, id_d;
   logic        nmi_prev_q;
   logic        nmi_pend_q, nmi_pend_d;

   logic             enc_valid;
   logic [IDX_W-1:0] enc_idx;
   logic             nmi_edge, nmi_req;
   logic [15:0]      pc16;
   logic [7:0]       psr_push;

   irq_priority_enc #(
      .NUM_IRQ (NUM_IRQ),
      .IDX_W   (IDX_W)
   ) u_prio (
      .irq_i    (irq_i),
      .mask_i   (irq_mask_i),
      .i_flag_i (i_flag_i),
      .valid_o  (enc_valid),
      .idx_o    (enc_idx)
   );

   assign nmi_edge = nmi_i & ~nmi_prev_q;
   assign nmi_req  = nmi_pend_q | nmi_edge;
   assign pc16     = 16'(pc_in_i);

   always_comb begin
      psr_push        = psr_in_i;
      psr_push[PSR_U] = 1'b1;
      psr_push[PSR_B] = (kind_q == K_BRK);
   end

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      vec_d      = vec_q;
      sp_d       = sp_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      id_d       = id_q;
      nmi_pend_d = nmi_req;
      if (rdy_i) begin
         case (state_q)
            S_IDLE: begin
               if (insn_boundary_i) begin
                  if (nmi_req) begin
                     kind_d     = K_NMI;
                     vec_d      = NMI_VEC;
                     id_d       = '0;
                     nmi_pend_d = 1'b0;
                     sp_d       = sp_in_i;
                     state_d    = S_PUSH_PCH;
                  end else if (brk_req_i) begin
                     kind_d  = K_BRK;
                     vec_d   = IRQ_VEC;
                     id_d    = '0;
                     sp_d    = sp_in_i;
                     state_d = S_PUSH_PCH;
                  end else if (enc_valid) begin
                     kind_d  = K_IRQ;
                     vec_d   = irq_vector(VEC_BASE, 8'(enc_idx));
                     id_d    = ID_W'(enc_idx) + ID_W'(1);
                     sp_d    = sp_in_i;
                     state_d = S_PUSH_PCH;
                  end
               end
            end
            S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P: begin
               sp_d = sp_q - 8'd1;
               if (state_q == S_PUSH_PCH) begin
                  state_d = S_PUSH_PCL;
               end else if (state_q == S_PUSH_PCL) begin
                  state_d = S_PUSH_P;
               end else begin
                  state_d = S_VEC_LO;
               end
`ifdef TINYMOS6502_NMI_HIJACK_EN
               // Kind is left alone so the pushed B bit still reflects the original entry.
               if (nmi_req && (kind_q != K_NMI) && (vec_q != NMI_VEC)) begin
                  vec_d      = NMI_VEC;
                  id_d       = '0;
                  nmi_pend_d = 1'b0;
               end
`endif
            end
            S_VEC_LO: begin
               lo_d    = data_in_i[7:0];
               state_d = S_VEC_HI;
            end
            S_VEC_HI: begin
               hi_d    = data_in_i[7:0];
               state_d = S_LOAD_PC;
            end
            S_LOAD_PC: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // The NMI edge detector keeps running during RDY stalls so a short pulse is never lost.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         nmi_prev_q <= 1'b0;
         nmi_pend_q <= 1'b0;
      end else begin
         nmi_prev_q <= nmi_i;
         nmi_pend_q <= nmi_pend_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_VEC_LO;
         kind_q  <= K_RESET;
         vec_q   <= RST_VEC;
         sp_q    <= 8'd0;
         lo_q    <= 8'd0;
         hi_q    <= 8'd0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         vec_q   <= vec_d;
         sp_q    <= sp_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         id_q    <= id_d;
      end
   end

   always_comb begin
      busy_o     = (state_q != S_IDLE);
      rw_o       = 1'b1;
      address_o  = '0;
      data_out_o = '0;
      pc_out_o   = '0;
      pc_we_o    = 1'b0;
      sp_out_o   = 8'd0;
      sp_we_o    = 1'b0;
      set_i_o    = 1'b0;
      case (state_q)
         S_PUSH_PCH: begin
            rw_o       = 1'b0;
            address_o  = ADDR_WIDTH'({STACK_PAGE, sp_q});
            data_out_o = DATA_WIDTH'(pc16[15:8]);
         end
         S_PUSH_PCL: begin
            rw_o       = 1'b0;
            address_o  = ADDR_WIDTH'({STACK_PAGE, sp_q});
            data_out_o = DATA_WIDTH'(pc16[7:0]);
         end
         S_PUSH_P: begin
            rw_o       = 1'b0;
            address_o  = ADDR_WIDTH'({STACK_PAGE, sp_q});
            data_out_o = DATA_WIDTH'(psr_push);
         end
         S_VEC_LO: address_o = ADDR_WIDTH'(vec_q);
         S_VEC_HI: address_o = ADDR_WIDTH'(vec_q + 16'd1);
         S_LOAD_PC: begin
            pc_out_o = ADDR_WIDTH'({hi_q, lo_q});
            pc_we_o  = 1'b1;
            set_i_o  = 1'b1;
            sp_out_o = sp_q;
            sp_we_o  = (kind_q != K_RESET);
         end
         default: ;
      endcase
   end

   assign irq_id_o = id_q;

endmodule

// File: tb/tb_irq_stack_sequencer.sv
// tb/tb_irq_stack_sequencer.sv - directed self-checking bench for irq_stack_sequencer
module tb_irq_stack_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, rdy, nmi, brk_req, insn_boundary, i_flag;
   logic [3:0]  irq, irq_mask;
   logic [15:0] pc_in;
   logic [7:0]  psr_in, sp_in, data_in;
   logic [15:0] address, pc_out;
   logic [7:0]  data_out, sp_out;
   logic        rw, busy, pc_we, sp_we, set_i;
   logic [2:0]  irq_id;

   int checks = 0;
   int errors = 0;

   logic [15:0] wa [3];
   logic [7:0]  wd [3];
   logic [15:0] ra [2];
   int          nw, nr, lat;
   bit          frozen;
   logic [15:0] seen_pc;
   logic [7:0]  seen_sp;
   logic        seen_spwe, seen_seti;
   logic [2:0]  seen_id;

   irq_stack_sequencer dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .rdy_i           (rdy),
      .nmi_i           (nmi),
      .irq_i           (irq),
      .irq_mask_i      (irq_mask),
      .i_flag_i        (i_flag),
      .brk_req_i       (brk_req),
      .insn_boundary_i (insn_boundary),
      .pc_in_i         (pc_in),
      .psr_in_i        (psr_in),
      .sp_in_i         (sp_in),
      .data_in_i       (data_in),
      .address_o       (address),
      .data_out_o      (data_out),
      .rw_o            (rw),
      .busy_o          (busy),
      .pc_out_o        (pc_out),
      .pc_we_o         (pc_we),
      .sp_out_o        (sp_out),
      .sp_we_o         (sp_we),
      .set_i_o         (set_i),
      .irq_id_o        (irq_id)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_rd(input logic [15:0] a);
      case (a)
         16'hFFFA: return 8'h00;
         16'hFFFB: return 8'h90;
         16'hFFFC: return 8'h34;
         16'hFFFD: return 8'h12;
         16'hFFFE: return 8'h00;
         16'hFFFF: return 8'h80;
         16'hFFE4: return 8'h00;
         16'hFFE5: return 8'hA0;
         default:  return 8'hEE;
      endcase
   endfunction

   assign data_in = mem_rd(address);

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Runs one entry sequence from a boundary cycle already set up by the caller and records the bus.
   task automatic run_seq(input int stall_n, input bit nmi_inj);
      int cyc;
      bit done, injected;
      logic [15:0] a0;
      logic [7:0]  d0;
      logic        r0;
      for (int i = 0; i < 3; i++) begin wa[i] = 'x; wd[i] = 'x; end
      for (int i = 0; i < 2; i++) ra[i] = 'x;
      nw = 0; nr = 0; lat = -1; frozen = 1'b1;
      seen_pc = 'x; seen_sp = 'x; seen_spwe = 1'b0; seen_seti = 1'b0; seen_id = 'x;
      cyc = 0; done = 1'b0; injected = 1'b0;
      while (!done && cyc < 40) begin
         step();
         cyc++;
         insn_boundary = 1'b0;
         if (injected) begin nmi = 1'b0; injected = 1'b0; end
         if (sp_we) seen_spwe = 1'b1;
         if (busy && !rw) begin
            if (nw < 3) begin wa[nw] = address; wd[nw] = data_out; end
            nw++;
            if (nw == 2 && stall_n > 0) begin
               a0 = address; d0 = data_out; r0 = rw;
               rdy = 1'b0;
               for (int s = 0; s < stall_n; s++) begin
                  step();
                  cyc++;
                  if (address !== a0 || data_out !== d0 || rw !== r0 || busy !== 1'b1 || pc_we !== 1'b0)
                     frozen = 1'b0;
               end
               rdy = 1'b1;
            end
            if (nw == 2 && nmi_inj) begin nmi = 1'b1; injected = 1'b1; end
         end else if (busy && rw && !pc_we && address != 16'h0000) begin
            if (nr < 2) ra[nr] = address;
            nr++;
         end
         if (pc_we) begin
            lat = cyc; seen_pc = pc_out; seen_sp = sp_out;
            seen_seti = set_i; seen_id = irq_id; done = 1'b1;
         end
      end
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b1; rdy = 1'b1; nmi = 1'b0; brk_req = 1'b0; insn_boundary = 1'b0; i_flag = 1'b0;
      irq = 4'h0; irq_mask = 4'hF; pc_in = 16'h0000; psr_in = 8'h00; sp_in = 8'hFF;
      #1 rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      checks++; if (busy !== 1'b1 || rw !== 1'b1) begin errors++; $display("FAIL rst_busy_rw got %b%b exp 11", busy, rw); end
      checks++; if (address !== 16'hFFFC) begin errors++; $display("FAIL rst_addr got %h exp fffc", address); end
      checks++; if ({pc_we, sp_we, set_i} !== 3'b000 || irq_id !== 3'd0) begin errors++; $display("FAIL rst_strobes got %b id %0d exp 000 id 0", {pc_we, sp_we, set_i}, irq_id); end
      rst_n = 1'b1;
      step();
      checks++; if (address !== 16'hFFFD || rw !== 1'b1) begin errors++; $display("FAIL rst_vec_hi got %h rw %b exp fffd rw 1", address, rw); end
      step();
      checks++; if (pc_we !== 1'b1 || pc_out !== 16'h1234) begin errors++; $display("FAIL rst_pc got we %b pc %h exp we 1 pc 1234", pc_we, pc_out); end
      checks++; if (sp_we !== 1'b0 || set_i !== 1'b1 || rw !== 1'b1) begin errors++; $display("FAIL rst_load got spwe %b seti %b rw %b exp 0 1 1", sp_we, set_i, rw); end
      step();
      checks++; if (busy !== 1'b0 || address !== 16'h0000 || data_out !== 8'h00) begin errors++; $display("FAIL rst_idle got busy %b addr %h dout %h exp 0 0000 00", busy, address, data_out); end
   endtask

   task automatic test_irq0();
      sp_in = 8'hFF; pc_in = 16'hC005; psr_in = 8'h03; irq = 4'b0001; i_flag = 1'b0; insn_boundary = 1'b1;
      run_seq(0, 1'b0);
      irq = 4'h0;
      checks++; if (nw !== 3 || wa[0] !== 16'h01FF || wa[1] !== 16'h01FE || wa[2] !== 16'h01FD) begin errors++; $display("FAIL irq0_waddr got n%0d %h %h %h exp 01ff 01fe 01fd", nw, wa[0], wa[1], wa[2]); end
      checks++; if (wd[0] !== 8'hC0 || wd[1] !== 8'h05 || wd[2] !== 8'h23) begin errors++; $display("FAIL irq0_wdata got %h %h %h exp c0 05 23", wd[0], wd[1], wd[2]); end
      checks++; if (ra[0] !== 16'hFFFE || ra[1] !== 16'hFFFF) begin errors++; $display("FAIL irq0_reads got %h %h exp fffe ffff", ra[0], ra[1]); end
      checks++; if (seen_pc !== 16'h8000 || seen_sp !== 8'hFC || seen_spwe !== 1'b1 || seen_seti !== 1'b1) begin errors++; $display("FAIL irq0_load got pc %h sp %h spwe %b seti %b exp 8000 fc 1 1", seen_pc, seen_sp, seen_spwe, seen_seti); end
      checks++; if (lat !== 6 || seen_id !== 3'd1) begin errors++; $display("FAIL irq0_lat_id got %0d id %0d exp 6 id 1", lat, seen_id); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL irq0_idle got busy %b exp 0", busy); end
   endtask

   task automatic test_sp_wrap();
      sp_in = 8'h01; pc_in = 16'h4321; psr_in = 8'h81; irq = 4'b0001; insn_boundary = 1'b1;
      run_seq(0, 1'b0);
      irq = 4'h0;
      checks++; if (wa[0] !== 16'h0101 || wa[1] !== 16'h0100 || wa[2] !== 16'h01FF || wd[2] !== 8'hA1) begin errors++; $display("FAIL wrap_push got %h %h %h p %h exp 0101 0100 01ff a1", wa[0], wa[1], wa[2], wd[2]); end
      checks++; if (seen_sp !== 8'hFE) begin errors++; $display("FAIL wrap_sp got %h exp fe", seen_sp); end
   endtask

   task automatic test_masked_channel();
      irq = 4'b0110; irq_mask = 4'b0100; sp_in = 8'hFF; psr_in = 8'h03; insn_boundary = 1'b1;
      run_seq(0, 1'b0);
      checks++; if (ra[0] !== 16'hFFE4 || ra[1] !== 16'hFFE5 || seen_pc !== 16'hA000) begin errors++; $display("FAIL chan2_vec got %h %h pc %h exp ffe4 ffe5 a000", ra[0], ra[1], seen_pc); end
      checks++; if (seen_id !== 3'd3) begin errors++; $display("FAIL chan2_id got %0d exp 3", seen_id); end
      i_flag = 1'b1; insn_boundary = 1'b1;
      step();
      insn_boundary = 1'b0;
      step();
      checks++; if (busy !== 1'b0 || rw !== 1'b1) begin errors++; $display("FAIL iflag_idle got busy %b rw %b exp 0 1", busy, rw); end
      i_flag = 1'b0; irq = 4'h0; irq_mask = 4'hF;
   endtask

   task automatic test_nmi_priority();
      irq = 4'b0001; nmi = 1'b1; insn_boundary = 1'b1;
      run_seq(0, 1'b0);
      checks++; if (ra[0] !== 16'hFFFA || seen_pc !== 16'h9000 || seen_id !== 3'd0) begin errors++; $display("FAIL nmi_first got %h pc %h id %0d exp fffa 9000 0", ra[0], seen_pc, seen_id); end
      checks++; if (wd[2] !== 8'h23) begin errors++; $display("FAIL nmi_p got %h exp 23", wd[2]); end
      insn_boundary = 1'b1;
      run_seq(0, 1'b0);
      checks++; if (ra[0] !== 16'hFFFE || seen_id !== 3'd1) begin errors++; $display("FAIL nmi_then_irq got %h id %0d exp fffe 1", ra[0], seen_id); end
      nmi = 1'b0; irq = 4'h0;
   endtask

   task automatic test_brk_stall();
      psr_in = 8'h00; brk_req = 1'b1; sp_in = 8'hFF; insn_boundary = 1'b1;
      run_seq(3, 1'b0);
      brk_req = 1'b0;
      checks++; if (wd[2] !== 8'h30 || ra[0] !== 16'hFFFE || seen_id !== 3'd0) begin errors++; $display("FAIL brk_p got %h vec %h id %0d exp 30 fffe 0", wd[2], ra[0], seen_id); end
      checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL brk_frozen got %b exp 1", frozen); end
      checks++; if (lat !== 9) begin errors++; $display("FAIL brk_lat got %0d exp 9", lat); end
   endtask

   task automatic test_nmi_during_irq();
      irq = 4'b0001; psr_in = 8'h03; insn_boundary = 1'b1;
      run_seq(0, 1'b1);
      irq = 4'h0;
`ifdef TINYMOS6502_NMI_HIJACK_EN
      checks++; if (ra[0] !== 16'hFFFA || ra[1] !== 16'hFFFB || seen_id !== 3'd0) begin errors++; $display("FAIL hijack_vec got %h %h id %0d exp fffa fffb 0", ra[0], ra[1], seen_id); end
      checks++; if (wd[2] !== 8'h23) begin errors++; $display("FAIL hijack_p got %h exp 23", wd[2]); end
      insn_boundary = 1'b1;
      step();
      insn_boundary = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hijack_cleared got busy %b exp 0", busy); end
`else
      checks++; if (ra[0] !== 16'hFFFE || seen_id !== 3'd1) begin errors++; $display("FAIL late_nmi_irq got %h id %0d exp fffe 1", ra[0], seen_id); end
      insn_boundary = 1'b1;
      run_seq(0, 1'b0);
      checks++; if (ra[0] !== 16'hFFFA || ra[1] !== 16'hFFFB || seen_id !== 3'd0) begin errors++; $display("FAIL late_nmi_next got %h %h id %0d exp fffa fffb 0", ra[0], ra[1], seen_id); end
`endif
   endtask

   task automatic test_reset_abort();
      irq = 4'b0001; sp_in = 8'hFF; insn_boundary = 1'b1;
      step();
      insn_boundary = 1'b0;
      step();
      #1 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b1 || address !== 16'hFFFC || rw !== 1'b1) begin errors++; $display("FAIL abort_state got busy %b addr %h rw %b exp 1 fffc 1", busy, address, rw); end
      checks++; if (sp_we !== 1'b0 || pc_we !== 1'b0 || irq_id !== 3'd0) begin errors++; $display("FAIL abort_strobes got spwe %b pcwe %b id %0d exp 0 0 0", sp_we, pc_we, irq_id); end
      irq = 4'h0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      checks++; if (pc_we !== 1'b1 || pc_out !== 16'h1234 || sp_we !== 1'b0) begin errors++; $display("FAIL abort_reload got we %b pc %h spwe %b exp 1 1234 0", pc_we, pc_out, sp_we); end
      step();
   endtask

   initial begin
      test_reset();
      test_irq0();
      test_sp_wrap();
      test_masked_channel();
      test_nmi_priority();
      test_brk_stall();
      test_nmi_during_irq();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
